// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Unified instruction/data memory stage of the multi-cycle RV32I core. The
// control FSM raises mem_read or mem_write together with i_or_d / IR_write.
// This block holds a word-addressed memory and inserts LATENCY cycles of wait
// time per access. On completion it latches the fetched word into the
// instruction register (fetch) or the memory data register (load). It then
// pulses mem_ready for exactly one cycle.
//
// Handshake: a request (mem_read|mem_write) is accepted only in IDLE.
// Acceptance occurs at the sampling edge t0. The access completes at edge
// t0+LATENCY, where mem_ready rises for exactly one cycle. The unit is back in
// IDLE at edge t0+LATENCY+1. A request seen while BUSY or DONE is not queued;
// it is dropped and recorded in the sticky protocol_err flag.
//
// Parameters
//   XLEN        data/address width
//   ADDR_WIDTH  word-index width, DEPTH = 2**ADDR_WIDTH words
//   LATENCY     request-edge to mem_ready distance in cycles, 1..15
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   mem_read      read request
//   mem_write     write request
//   i_or_d        address select: 0 = pc, 1 = alu_out
//   IR_write      read result goes to inst (else mdr when i_or_d = 1)
//   pc            instruction byte address
//   alu_out       data byte address
//   write_data    store data
//   inst          instruction register
//   part_of_inst  inst[6:0]
//   mdr           memory data register
//   mem_opcode    low 7 bits of the last read word while mem_ready, else 0
//   mem_ready     one-cycle completion pulse
//   misaligned    sticky: a request carried addr[1:0] != 0
//   protocol_err  sticky: read+write together, or a request while busy
//   fsm_state     current FSM state (0 = IDLE, 1 = BUSY, 2 = DONE)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            i_or_d,
    input  logic            IR_write,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] inst,
    output logic [6:0]      part_of_inst,
    output logic [XLEN-1:0] mdr,
    output logic [6:0]      mem_opcode,
    output logic            mem_ready,
    output logic            misaligned,
    output logic            protocol_err,
    output logic [1:0]      fsm_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // The BUSY countdown starts at LATENCY-1. The access therefore fires on
    // the LATENCY-th edge after the request edge.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [XLEN-1:0]         wdata_q;
    logic [XLEN-1:0]         rdata_q;
    logic                    op_read_q;
    logic                    irw_q;
    logic                    dsel_q;
    logic [XLEN-1:0]         mem [DEPTH];

    logic [XLEN-1:0]         req_addr;
    logic                    request;
    logic                    access_now;

    assign req_addr   = i_or_d ? alu_out : pc;
    assign request    = mem_read | mem_write;
    assign access_now = (state == S_BUSY) && (cnt == 4'd0);

    // Byte offset and address bits above the word index do not select a word.
    // The upper bits of rdata_q are kept only for visibility in waveforms.
    logic unused_bits;
    assign unused_bits = ^{req_addr[XLEN-1:ADDR_WIDTH+2], rdata_q[XLEN-1:7]};

    // -------------------------------------------------------------------------
    // Control FSM, request capture and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            idx_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            op_read_q    <= 1'b0;
            irw_q        <= 1'b0;
            dsel_q       <= 1'b0;
            inst         <= '0;
            mdr          <= '0;
            mem_ready    <= 1'b0;
            misaligned   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_ready <= 1'b0;
                    if (request) begin
                        idx_q     <= req_addr[ADDR_WIDTH+1:2];
                        wdata_q   <= write_data;
                        // A read takes priority when both strobes are high.
                        // The write half is discarded.
                        op_read_q <= mem_read;
                        irw_q     <= IR_write;
                        dsel_q    <= i_or_d;
                        cnt       <= CNT_INIT;
                        state     <= S_BUSY;
                        if (req_addr[1:0] != 2'b00) begin
                            misaligned <= 1'b1;
                        end
                        if (mem_read && mem_write) begin
                            protocol_err <= 1'b1;
                        end
                    end
                end

                S_BUSY: begin
                    if (request) begin
                        protocol_err <= 1'b1;
                    end
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (op_read_q) begin
                            rdata_q <= mem[idx_q];
                            // A data read with IR_write low and i_or_d low
                            // updates only rdata_q.
                            if (irw_q) begin
                                inst <= mem[idx_q];
                            end else if (dsel_q) begin
                                mdr <= mem[idx_q];
                            end
                        end
                        mem_ready <= 1'b1;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (request) begin
                        protocol_err <= 1'b1;
                    end
                    mem_ready <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    mem_ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory array write port. The array is not reset.
    // An asynchronous reset forces state to IDLE. This gating therefore drops
    // any write still counting down in BUSY.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (access_now && !op_read_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign part_of_inst = inst[6:0];
    assign mem_opcode   = mem_ready ? rdata_q[6:0] : 7'd0;
    assign fsm_state    = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Drives three copies of mem_access_unit (LATENCY = 1, 2, 15) with identical
// request streams. Every request is issued only once all copies are idle.
// Memory contents and register values therefore match across copies, and only
// the completion timing differs. A behavioural model (associative word memory
// plus expected register values) predicts every outcome.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int N  = 3;
    localparam int XW = 32;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 15;
        endcase
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          mem_read, mem_write, i_or_d, ir_write;
    logic [XW-1:0] pc, alu_out, write_data;

    logic [XW-1:0] inst_v [N];
    logic [XW-1:0] mdr_v  [N];
    logic [6:0]    pinst_v[N];
    logic [6:0]    opc_v  [N];
    logic          rdy_v  [N];
    logic          mis_v  [N];
    logic          perr_v [N];
    logic [1:0]    st_v   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_access_unit #(
            .XLEN      (32),
            .ADDR_WIDTH(10),
            .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 2 : 15))
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .mem_read    (mem_read),
            .mem_write   (mem_write),
            .i_or_d      (i_or_d),
            .IR_write    (ir_write),
            .pc          (pc),
            .alu_out     (alu_out),
            .write_data  (write_data),
            .inst        (inst_v[g]),
            .part_of_inst(pinst_v[g]),
            .mdr         (mdr_v[g]),
            .mem_opcode  (opc_v[g]),
            .mem_ready   (rdy_v[g]),
            .misaligned  (mis_v[g]),
            .protocol_err(perr_v[g]),
            .fsm_state   (st_v[g])
        );
    end

    // ---------------- reference model / scoreboard ----------------
    int            compared   = 0;
    int            mismatched = 0;
    logic [XW-1:0] ref_mem [int];
    logic [XW-1:0] m_inst, m_mdr, m_rdata;
    logic          m_mis, m_perr;
    logic [XW-1:0] exp_q[$];

    // per-access observations
    int            rdy_cnt[N];
    int            rdy_k  [N];
    int            opc_bad[N];
    logic [6:0]    opc_rdy[N];
    logic [6:0]    exp_opc;

    task automatic model_reset();
        m_inst  = '0;
        m_mdr   = '0;
        m_rdata = '0;
        m_mis   = 1'b0;
        m_perr  = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver + monitor ----------------
    // Issues one request, optionally pokes mem_read on the first BUSY edge,
    // then watches 18 cycles. Completion is at most 15 cycles away.
    task automatic do_access(input bit rd, input bit wr, input bit ird, input bit iod,
                             input logic [XW-1:0] addr, input logic [XW-1:0] wdata,
                             input bit poke);
        int            idx;
        logic [XW-1:0] val;
        idx = int'(addr[11:2]);
        if (addr[1:0] != 2'b00) m_mis = 1'b1;
        if ((rd && wr) || poke) m_perr = 1'b1;
        if (rd) begin
            val = ref_mem.exists(idx) ? ref_mem[idx] : '0;
            m_rdata = val;
            exp_q.push_back(val);
            if (ird) m_inst = val;
            else if (iod) m_mdr = val;
        end else begin
            ref_mem[idx] = wdata;
        end
        exp_opc = m_rdata[6:0];

        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        ir_write   = ird;
        i_or_d     = iod;
        write_data = wdata;
        if (iod) begin
            alu_out = addr;
            pc      = $urandom;
        end else begin
            pc      = addr;
            alu_out = $urandom;
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            rdy_cnt[i] = 0;
            rdy_k[i]   = -1;
            opc_bad[i] = 0;
            opc_rdy[i] = '0;
        end
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            mem_read  = poke && (k == 1);
            mem_write = 1'b0;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rdy_v[i]) begin
                    rdy_cnt[i]++;
                    if (rdy_k[i] < 0) begin
                        rdy_k[i]   = k;
                        opc_rdy[i] = opc_v[i];
                    end
                end else if (opc_v[i] != 7'd0) begin
                    opc_bad[i]++;
                end
            end
        end
        @(negedge clk);
        mem_read = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            compared++;
            if ({inst_v[i], mdr_v[i], opc_v[i], rdy_v[i], mis_v[i], perr_v[i], st_v[i]} !== '0) begin
                mismatched++;
                $display("FAIL reset_state dut%0d: inst=%h mdr=%h opc=%h rdy=%b mis=%b perr=%b st=%0d, want all 0",
                         i, inst_v[i], mdr_v[i], opc_v[i], rdy_v[i], mis_v[i], perr_v[i], st_v[i]);
            end
        end
        reset = 1'b1;
        model_reset();

        // Known value at 0x40, then a write of DEADBEEF cut short by reset.
        do_access(0, 1, 0, 1, 32'h40, 32'h1111_1111, 0);
        @(negedge clk);
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        alu_out    = 32'h40;
        write_data = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        reset     = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            compared++;
            if ({inst_v[i], mdr_v[i], opc_v[i], rdy_v[i], mis_v[i], perr_v[i], st_v[i]} !== '0) begin
                mismatched++;
                $display("FAIL reset_mid_busy dut%0d: inst=%h mdr=%h rdy=%b st=%0d, want all 0",
                         i, inst_v[i], mdr_v[i], rdy_v[i], st_v[i]);
            end
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        do_access(1, 0, 0, 1, 32'h40, 32'h0, 0);
        for (int i = 0; i < N; i++) begin
            compared++;
            if (mdr_v[i] !== m_mdr || mdr_v[i] === 32'hDEAD_BEEF) begin
                mismatched++;
                $display("FAIL dropped_write dut%0d: mdr=%h, want %h", i, mdr_v[i], m_mdr);
            end
        end
    endtask

    task automatic test_fetch();
        do_access(0, 1, 0, 1, 32'h4, 32'h0000_006F, 0);
        do_access(1, 0, 1, 0, 32'h4, 32'h0, 0);
        for (int i = 0; i < N; i++) begin
            compared++;
            if (rdy_cnt[i] !== 1 || rdy_k[i] !== lat_of(i)) begin
                mismatched++;
                $display("FAIL fetch_timing dut%0d: %0d pulses first at %0d, want 1 at %0d",
                         i, rdy_cnt[i], rdy_k[i], lat_of(i));
            end
            compared++;
            if (opc_rdy[i] !== 7'h6F || opc_bad[i] !== 0) begin
                mismatched++;
                $display("FAIL fetch_opcode dut%0d: opc=%h stray=%0d, want 6f and 0", i, opc_rdy[i], opc_bad[i]);
            end
            compared++;
            if (inst_v[i] !== m_inst || pinst_v[i] !== m_inst[6:0] || m_inst !== 32'h6F) begin
                mismatched++;
                $display("FAIL fetch_inst dut%0d: inst=%h part=%h, want %h", i, inst_v[i], pinst_v[i], m_inst);
            end
        end
    endtask

    task automatic test_store_load();
        do_access(0, 1, 0, 1, 32'h10, 32'h1234_5678, 0);
        do_access(1, 0, 0, 1, 32'h10, 32'h0, 0);
        for (int i = 0; i < N; i++) begin
            compared++;
            if (mdr_v[i] !== 32'h1234_5678 || inst_v[i] !== m_inst || opc_rdy[i] !== exp_opc) begin
                mismatched++;
                $display("FAIL store_load dut%0d: mdr=%h inst=%h opc=%h, want %h %h %h",
                         i, mdr_v[i], inst_v[i], opc_rdy[i], 32'h1234_5678, m_inst, exp_opc);
            end
        end
    endtask

    task automatic test_misaligned();
        do_access(1, 0, 0, 1, 32'h13, 32'h0, 0);
        for (int i = 0; i < N; i++) begin
            compared++;
            if (mdr_v[i] !== 32'h1234_5678 || mis_v[i] !== 1'b1 || perr_v[i] !== 1'b0) begin
                mismatched++;
                $display("FAIL misaligned dut%0d: mdr=%h mis=%b perr=%b, want 12345678 1 0",
                         i, mdr_v[i], mis_v[i], perr_v[i]);
            end
        end
        do_access(1, 0, 1, 0, 32'h4, 32'h0, 0);
        for (int i = 0; i < N; i++) begin
            compared++;
            if (mis_v[i] !== m_mis || inst_v[i] !== m_inst) begin
                mismatched++;
                $display("FAIL mis_sticky dut%0d: mis=%b inst=%h, want %b %h", i, mis_v[i], inst_v[i], m_mis, m_inst);
            end
        end
    endtask

    task automatic test_protocol();
        do_access(0, 1, 0, 1, 32'h20, 32'h0A0B_0C0D, 0);
        do_access(1, 1, 0, 1, 32'h20, 32'hFFFF_0000, 1);
        for (int i = 0; i < N; i++) begin
            compared++;
            if (rdy_cnt[i] !== 1 || rdy_k[i] !== lat_of(i)) begin
                mismatched++;
                $display("FAIL proto_pulses dut%0d: %0d pulses first at %0d, want 1 at %0d",
                         i, rdy_cnt[i], rdy_k[i], lat_of(i));
            end
            compared++;
            if (mdr_v[i] !== m_mdr || perr_v[i] !== m_perr || m_perr !== 1'b1) begin
                mismatched++;
                $display("FAIL proto_read dut%0d: mdr=%h perr=%b, want %h %b", i, mdr_v[i], perr_v[i], m_mdr, m_perr);
            end
        end
        do_access(1, 0, 0, 1, 32'h20, 32'h0, 0);
        for (int i = 0; i < N; i++) begin
            compared++;
            if (mdr_v[i] !== 32'h0A0B_0C0D || perr_v[i] !== 1'b1) begin
                mismatched++;
                $display("FAIL proto_nowrite dut%0d: mdr=%h perr=%b, want 0a0b0c0d 1", i, mdr_v[i], perr_v[i]);
            end
        end
    endtask

    task automatic test_alias();
        logic [XW-1:0] d;
        d = $urandom;
        do_access(0, 1, 0, 1, 32'h1000, d, 0);
        do_access(1, 0, 1, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < N; i++) begin
            compared++;
            if (rdy_cnt[i] !== 1 || rdy_k[i] !== lat_of(i)) begin
                mismatched++;
                $display("FAIL alias_timing dut%0d: %0d pulses first at %0d, want 1 at %0d",
                         i, rdy_cnt[i], rdy_k[i], lat_of(i));
            end
            compared++;
            if (inst_v[i] !== d || opc_rdy[i] !== d[6:0]) begin
                mismatched++;
                $display("FAIL alias_data dut%0d: inst=%h opc=%h, want %h %h", i, inst_v[i], opc_rdy[i], d, d[6:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [XW-1:0] a, got;
        bit            rd, ird, iod;
        for (int w = 0; w < 8; w++) begin
            do_access(0, 1, 0, 1, 32'h100 + 32'(w * 4), $urandom, 0);
        end
        exp_q.delete();
        for (int n = 0; n < 30; n++) begin
            rd  = 1'($urandom_range(0, 1));
            ird = 1'($urandom_range(0, 1));
            iod = 1'($urandom_range(0, 1));
            a   = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3))
                  + ({$urandom} << 12);
            do_access(rd, !rd, ird, iod, a, $urandom, 0);
            got = rd ? exp_q.pop_front() : m_rdata;
            for (int i = 0; i < N; i++) begin
                compared++;
                if (rdy_cnt[i] !== 1 || rdy_k[i] !== lat_of(i) || opc_rdy[i] !== got[6:0] || opc_bad[i] !== 0) begin
                    mismatched++;
                    $display("FAIL rand_ready n%0d dut%0d: pulses=%0d at %0d opc=%h, want 1 at %0d opc=%h",
                             n, i, rdy_cnt[i], rdy_k[i], opc_rdy[i], lat_of(i), got[6:0]);
                end
                compared++;
                if (inst_v[i] !== m_inst || mdr_v[i] !== m_mdr || mis_v[i] !== m_mis ||
                    perr_v[i] !== m_perr || st_v[i] !== 2'd0) begin
                    mismatched++;
                    $display("FAIL rand_regs n%0d dut%0d: inst=%h mdr=%h mis=%b perr=%b st=%0d, want %h %h %b %b 0",
                             n, i, inst_v[i], mdr_v[i], mis_v[i], perr_v[i], st_v[i],
                             m_inst, m_mdr, m_mis, m_perr);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc         = '0;
        alu_out    = '0;
        write_data = '0;
        reset      = 1'b0;
        model_reset();
        test_reset();
        test_fetch();
        test_store_load();
        test_misaligned();
        test_protocol();
        test_alias();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
